shift_register_sequencer: RTL and testbench

- Controller for a WIDTH-stage D-flip-flop serial shift register datapath (4 stages by default).
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first into the register, one bit per shift-enable cycle.
- Holds an optional idle gap after the word, then pulses done.
- Keeps a shadow copy of the register contents so downstream logic and the bench can read the expected register state without tapping the flip-flops.

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_mirror.sv | 21 ++
 rtl/shift_register_sequencer.sv | 137 +++++++++++++
 tb/tb_shift_register_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and sizing helpers for the shift register sequencer.
// Holds the FSM state encoding, the gap counter width and a bit-count width helper.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int GAP_CNT_W = 8;

  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_mirror.sv
// Shadow copy of the WIDTH-stage serial shift register.
// Ports: clk, rst_n (sync, active-low), en (shift enable), din (stage 0 input), q (bit 0 = stage 0).
module shift_mirror #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/shift_register_sequencer.sv
// Serialises a handshaked parallel word MSB-first into a WIDTH-stage shift register.
// Ports: clock/reset, valid/data/abort in; ready, shift_en, serial, busy, done, bit_count, mirror out.
module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic                       input_clock1_1,
  input  logic                       input_reset_n_2,
  input  logic                       input_valid_3,
  input  logic [WIDTH-1:0]           input_data_4,
  input  logic                       input_abort_5,
  output logic                       output_ready_6,
  output logic                       output_shift_en_7,
  output logic                       output_serial_8,
  output logic                       output_busy_9,
  output logic                       output_done_10,
  output logic [bitcnt_w(WIDTH)-1:0] output_bit_count_11,
  output logic [WIDTH-1:0]           output_mirror_12
);

  localparam int BCW = bitcnt_w(WIDTH);

  localparam logic [BCW-1:0] BC_LAST =
    BCW'(WIDTH - 1);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t               state;
  logic [WIDTH-1:0]     sh_buf;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 shift_en_q;
  logic                 serial_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 hs;

  // Ready is gated by reset so nothing is accepted while it is held.
  assign output_ready_6 =
    (state == ST_IDLE) &&
    !input_abort_5 &&
    input_reset_n_2;

  assign hs = input_valid_3 && output_ready_6;

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge input_clock1_1) begin
    if (!input_reset_n_2) begin
      state      <= ST_IDLE;
      sh_buf     <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      shift_en_q <= 1'b0;
      serial_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (hs) begin
            state      <= ST_SHIFT;
            sh_buf     <= input_data_4;
            bit_cnt    <= '0;
            shift_en_q <= 1'b1;
            serial_q   <= input_data_4[WIDTH-1];
            busy_q     <= 1'b1;
          end
        end
        (state == ST_SHIFT): begin
          // The shift in this cycle always lands, even on abort.
          sh_buf  <= sh_buf << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (input_abort_5) begin
            state      <= ST_IDLE;
            shift_en_q <= 1'b0;
            serial_q   <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bit_cnt == BC_LAST) begin
            shift_en_q <= 1'b0;
            serial_q   <= 1'b0;
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end else begin
            serial_q <= sh_buf[WIDTH-2];
          end
        end
        (state == ST_GAP): begin
          if (input_abort_5) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        (state == ST_DONE): begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          shift_en_q <= 1'b0;
          serial_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign output_shift_en_7   = shift_en_q;
  assign output_serial_8     = serial_q;
  assign output_busy_9       = busy_q;
  assign output_done_10      = done_q;
  assign output_bit_count_11 = bit_cnt;

  shift_mirror #(
    .WIDTH (WIDTH)
  ) u_mirror (
    .clk   (input_clock1_1),
    .rst_n (input_reset_n_2),
    .en    (shift_en_q),
    .din   (serial_q),
    .q     (output_mirror_12)
  );

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench for shift_register_sequencer.
// Table-driven word transfers plus hand sequences for abort, gap and reset.
module tb_shift_register_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [3:0] data;
  logic       abort;

  logic       rdy0, en0, ser0, busy0, done0;
  logic [2:0] cnt0;
  logic [3:0] mir0;

  logic       rdy2, en2, ser2, busy2, done2;
  logic [2:0] cnt2;
  logic [3:0] mir2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_register_sequencer #(
    .WIDTH (4),
    .GAP   (0)
  ) u0 (
    .input_clock1_1      (clk),
    .input_reset_n_2     (rst_n),
    .input_valid_3       (valid),
    .input_data_4        (data),
    .input_abort_5       (abort),
    .output_ready_6      (rdy0),
    .output_shift_en_7   (en0),
    .output_serial_8     (ser0),
    .output_busy_9       (busy0),
    .output_done_10      (done0),
    .output_bit_count_11 (cnt0),
    .output_mirror_12    (mir0)
  );

  shift_register_sequencer #(
    .WIDTH (4),
    .GAP   (2)
  ) u2 (
    .input_clock1_1      (clk),
    .input_reset_n_2     (rst_n),
    .input_valid_3       (valid),
    .input_data_4        (data),
    .input_abort_5       (abort),
    .output_ready_6      (rdy2),
    .output_shift_en_7   (en2),
    .output_serial_8     (ser2),
    .output_busy_9       (busy2),
    .output_done_10      (done2),
    .output_bit_count_11 (cnt2),
    .output_mirror_12    (mir2)
  );

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        a;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(
    input logic       v,
    input logic [3:0] d,
    input logic       r,
    input logic       en,
    input logic       s,
    input logic       b,
    input logic       dn,
    input logic [2:0] c,
    input logic [3:0] m
  );
    vec_t t;
    t.v   = v;
    t.d   = d;
    t.a   = 1'b0;
    t.exp = {r, en, s, b, dn, c, m};
    return t;
  endfunction

  function automatic logic [11:0] obs0();
    return {rdy0, en0, ser0, busy0, done0, cnt0, mir0};
  endfunction

  task automatic check(
    input string       name,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Word 1011, then 1100/0011 back-to-back with valid held.
    // Fields: v d ready en serial busy done cnt mirror.
    vecs[0]  = mk(1, 4'b1011, 1, 0, 0, 0, 0, 0, 4'b0000);
    vecs[1]  = mk(0, 4'b0000, 0, 1, 1, 1, 0, 0, 4'b0000);
    vecs[2]  = mk(0, 4'b0000, 0, 1, 0, 1, 0, 1, 4'b0001);
    vecs[3]  = mk(0, 4'b0000, 0, 1, 1, 1, 0, 2, 4'b0010);
    vecs[4]  = mk(0, 4'b0000, 0, 1, 1, 1, 0, 3, 4'b0101);
    vecs[5]  = mk(0, 4'b0000, 0, 0, 0, 1, 1, 4, 4'b1011);
    vecs[6]  = mk(0, 4'b0000, 1, 0, 0, 0, 0, 4, 4'b1011);
    vecs[7]  = mk(1, 4'b1100, 1, 0, 0, 0, 0, 4, 4'b1011);
    vecs[8]  = mk(1, 4'b0011, 0, 1, 1, 1, 0, 0, 4'b1011);
    vecs[9]  = mk(1, 4'b0011, 0, 1, 1, 1, 0, 1, 4'b0111);
    vecs[10] = mk(1, 4'b0011, 0, 1, 0, 1, 0, 2, 4'b1111);
    vecs[11] = mk(1, 4'b0011, 0, 1, 0, 1, 0, 3, 4'b1110);
    vecs[12] = mk(1, 4'b0011, 0, 0, 0, 1, 1, 4, 4'b1100);
    vecs[13] = mk(1, 4'b0011, 1, 0, 0, 0, 0, 4, 4'b1100);
    vecs[14] = mk(0, 4'b0000, 0, 1, 0, 1, 0, 0, 4'b1100);
    vecs[15] = mk(0, 4'b0000, 0, 1, 0, 1, 0, 1, 4'b1000);
    vecs[16] = mk(0, 4'b0000, 0, 1, 1, 1, 0, 2, 4'b0000);
    vecs[17] = mk(0, 4'b0000, 0, 1, 1, 1, 0, 3, 4'b0001);
    vecs[18] = mk(0, 4'b0000, 0, 0, 0, 1, 1, 4, 4'b0011);
    vecs[19] = mk(0, 4'b0000, 1, 0, 0, 0, 0, 4, 4'b0011);

    // Reset held 3 cycles with valid high.
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 4'b1111;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("reset_hold",
        {rdy0, busy0, en0, done0, mir0},
        {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
    end
    tick();
    rst_n = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset",
      {11'd0, rdy0}, 12'd1);
    tick();

    for (int i = 0; i < 20; i++) begin
      valid = vecs[i].v;
      data  = vecs[i].d;
      abort = vecs[i].a;
      @(negedge clk);
      check($sformatf("vec%0d", i), obs0(), vecs[i].exp);
      tick();
    end

    // Abort in third shift cycle of 1010.
    do_reset();
    valid = 1'b1;
    data  = 4'b1010;
    tick();
    valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_en",
      {11'd0, en0}, 12'd1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_after",
      obs0(),
      {1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
       3'd3, 4'b0101});
    tick();
    @(negedge clk);
    check("abort_no_done",
      {10'd0, done0, busy0}, 12'd0);

    // GAP=2 instance: shift cycles 1..4, done in cycle 7.
    do_reset();
    valid = 1'b1;
    data  = 4'b1111;
    tick();
    valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("gap_c%0d", c),
        {10'd0, en2, done2},
        {10'd0, (c <= 4) ? 1'b1 : 1'b0,
         (c == 7) ? 1'b1 : 1'b0});
      tick();
    end
    @(negedge clk);
    check("gap_mirror",
      {8'd0, mir2}, {8'd0, 4'b1111});

    // Abort with valid in IDLE blocks acceptance once.
    valid = 1'b1;
    abort = 1'b1;
    data  = 4'b0110;
    @(negedge clk);
    check("idle_abort_ready",
      {11'd0, rdy0}, 12'd0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_blocked",
      {10'd0, rdy0, busy0}, 12'b10);
    tick();
    valid = 1'b0;
    @(negedge clk);
    check("idle_abort_accept",
      {8'd0, busy0, en0, ser0, 1'b0},
      {8'd0, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset mid-word clears everything.
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midreset_clear",
      obs0(), 12'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_release",
      obs0(),
      {1'b1, 11'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
